// File: rtl/value_reg_arbiter.sv
// Round-robin arbiter sharing one W-bit value register between NREQ requesters,
// with a programmable cooldown. Optional upd_cnt output: VALUE_REG_ARB_UPD_CNT_EN.
module value_reg_arbiter #(
  parameter int NREQ     = 4,
  parameter int W        = 4,
  parameter int RST_VAL  = 9,
  parameter int HOLD_CYC = 2
) (
  input  logic              ck,
  input  logic              arst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_val,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic [W-1:0]      out_val,
  output logic              out_vld
`ifdef VALUE_REG_ARB_UPD_CNT_EN
  ,
  output logic [7:0]        upd_cnt
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = 4;
  localparam logic [CW-1:0] COOL_INIT = CW'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

  typedef enum logic [1:0] {IDLE = 2'd0, UPD = 2'd1, COOL = 2'd2} state_t;

  state_t                   state, stateNxt;
  logic [PW-1:0]            rrPtr, winQ, winIdx;
  logic                     winFound;
  logic [CW-1:0]            coolCnt;
  logic [W-1:0]             dataQ;
  logic [NREQ-1:0][W-1:0]   reqVec;

  assign reqVec = req_val;

  // Priority search starting at rrPtr; wrap is explicit so any NREQ works.
  always_comb begin
    logic [PW:0] idx;
    idx      = '0;
    winIdx   = '0;
    winFound = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, rrPtr} + (PW+1)'(k);
      if (idx >= (PW+1)'(NREQ)) idx = idx - (PW+1)'(NREQ);
      if (!winFound && req[idx[PW-1:0]]) begin
        winFound = 1'b1;
        winIdx   = idx[PW-1:0];
      end
    end
  end

  always_ff @(posedge ck or posedge arst) begin
    if (arst) state <= IDLE;
    else      state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    case (state)
      IDLE:    if (winFound) stateNxt = UPD;
      UPD:     stateNxt = (HOLD_CYC == 0) ? IDLE : COOL;
      COOL:    if (coolCnt == '0) stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // req is only looked at in IDLE; captured value is frozen in dataQ.
  always_ff @(posedge ck or posedge arst) begin
    if (arst) begin
      gnt     <= '0;
      out_val <= W'(RST_VAL);
      out_vld <= 1'b0;
      rrPtr   <= '0;
      coolCnt <= '0;
      dataQ   <= '0;
      winQ    <= '0;
    end else begin
      gnt     <= '0;
      out_vld <= 1'b0;
      case (state)
        IDLE: if (winFound) begin
          gnt   <= NREQ'(1) << winIdx;
          dataQ <= reqVec[winIdx];
          winQ  <= winIdx;
        end
        UPD: begin
          out_val <= dataQ;
          out_vld <= 1'b1;
          rrPtr   <= (winQ == PW'(NREQ-1)) ? '0 : winQ + PW'(1);
          coolCnt <= COOL_INIT;
        end
        COOL: if (coolCnt != '0) coolCnt <= coolCnt - CW'(1);
        default: ;
      endcase
    end
  end

`ifdef VALUE_REG_ARB_UPD_CNT_EN
  // Bumped on the same edge that raises out_vld, so it reads the new total with the pulse.
  always_ff @(posedge ck or posedge arst) begin
    if (arst)                                 upd_cnt <= '0;
    else if (state == UPD && upd_cnt != 8'hFF) upd_cnt <= upd_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_value_reg_arbiter.sv
// Bench for value_reg_arbiter: a HOLD_CYC=2 and a HOLD_CYC=0 instance checked
// against a transaction-timeline model (grant edge -> gnt/out_vld/busy cycles).
module tb_value_reg_arbiter;
  localparam int N = 4;
  localparam int W = 4;
  localparam logic [N+W+1:0] RSTV = {4'b0000, 1'b0, 4'h9, 1'b0};

  logic ck = 1'b0;
  logic arst;
  logic [N-1:0]   req, req0, gnt, gnt0;
  logic [N*W-1:0] rv, rv0;
  logic [W-1:0]   oVal, oVal0;
  logic           oVld, oVld0, busy, busy0;
`ifdef VALUE_REG_ARB_UPD_CNT_EN
  logic [7:0]     cnt, cnt0;
`endif

  value_reg_arbiter #(.NREQ(N), .W(W), .RST_VAL(9), .HOLD_CYC(2)) dut (
    .ck(ck), .arst(arst), .req(req), .req_val(rv), .gnt(gnt), .busy(busy),
    .out_val(oVal), .out_vld(oVld)
`ifdef VALUE_REG_ARB_UPD_CNT_EN
    , .upd_cnt(cnt)
`endif
  );

  value_reg_arbiter #(.NREQ(N), .W(W), .RST_VAL(9), .HOLD_CYC(0)) dut0 (
    .ck(ck), .arst(arst), .req(req0), .req_val(rv0), .gnt(gnt0), .busy(busy0),
    .out_val(oVal0), .out_vld(oVld0)
`ifdef VALUE_REG_ARB_UPD_CNT_EN
    , .upd_cnt(cnt0)
`endif
  );

  always #5 ck = ~ck;

  logic [N+W+1:0] got0, got1;
  assign got0 = {gnt, oVld, oVal, busy};
  assign got1 = {gnt0, oVld0, oVal0, busy0};

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  // Model: one outstanding transaction per instance, described by cycle numbers.
  int             hold[2];
  int             mPtr[2], mFree[2], mGntCyc[2], mVldCyc[2], mBusyFrom[2], mBusyTo[2], mCnt[2];
  logic [N-1:0]   mGnt[2];
  logic [W-1:0]   mCur[2], mNext[2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mPtr[d] = 0; mFree[d] = 0; mGntCyc[d] = -1; mVldCyc[d] = -1;
      mBusyFrom[d] = 1; mBusyTo[d] = 0; mCnt[d] = 0;
      mGnt[d] = '0; mCur[d] = 4'h9; mNext[d] = 4'h9;
    end
  endtask

  task automatic model_edge(input int d, input logic [N-1:0] r, input logic [N*W-1:0] v);
    int w;
    w = -1;
    if (cyc >= mFree[d] && r != '0) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (mPtr[d] + k) % N;
        if (w < 0 && r[idx]) w = idx;
      end
      if (mVldCyc[d] >= 0) begin
        mCur[d] = mNext[d];
        mCnt[d] = (mCnt[d] < 255) ? mCnt[d] + 1 : 255;
      end
      mGnt[d]      = '0;
      mGnt[d][w]   = 1'b1;
      mNext[d]     = v[w*W +: W];
      mGntCyc[d]   = cyc;
      mVldCyc[d]   = cyc + 1;
      mBusyFrom[d] = cyc;
      mBusyTo[d]   = cyc + hold[d];
      mFree[d]     = cyc + hold[d] + 2;
      mPtr[d]      = (w + 1) % N;
    end
  endtask

  function automatic logic [N+W+1:0] expVec(input int d);
    logic [N-1:0] g;
    logic [W-1:0] val;
    logic         v, b;
    g   = (cyc == mGntCyc[d]) ? mGnt[d] : '0;
    v   = (cyc == mVldCyc[d]);
    val = (mVldCyc[d] >= 0 && cyc >= mVldCyc[d]) ? mNext[d] : mCur[d];
    b   = (cyc >= mBusyFrom[d] && cyc <= mBusyTo[d]);
    return {g, v, val, b};
  endfunction

  function automatic int expCnt(input int d);
    int c;
    c = mCnt[d] + ((mVldCyc[d] >= 0 && cyc >= mVldCyc[d]) ? 1 : 0);
    return (c > 255) ? 255 : c;
  endfunction

  function automatic int onehotIdx(input logic [N-1:0] g);
    int r;
    r = -1;
    for (int k = 0; k < N; k++) if (g[k]) r = k;
    return r;
  endfunction

  // Edge then sample at the following negedge; inputs change only after sampling.
  task automatic tick();
    @(posedge ck);
    cyc++;
    if (!arst) begin
      model_edge(0, req, rv);
      model_edge(1, req0, rv0);
    end
    @(negedge ck);
  endtask

  task automatic pulse_reset();
    #2 arst = 1'b1;
    req = '0; req0 = '0;
    model_reset();
    tick();
    arst = 1'b0;
  endtask

  task automatic test_reset();
    arst = 1'b1; req = '0; rv = '0; req0 = '0; rv0 = '0;
    model_reset();
    tick(); tick();
    total++; if (got0 !== RSTV) $display("FAIL reset_initial got %h exp %h", got0, RSTV); else passed++;
    arst = 1'b0; req = 4'b1111; rv = 16'h4321;
    tick();
    total++; if (got0 !== expVec(0)) $display("FAIL reset_first got %h exp %h", got0, expVec(0)); else passed++;
    #2 arst = 1'b1;
    #1;
    total++; if (got0 !== RSTV) $display("FAIL reset_async got %h exp %h", got0, RSTV); else passed++;
    model_reset();
    tick();
    arst = 1'b0;
    tick();
    total++; if (gnt !== 4'b0001) $display("FAIL reset_gnt0 got %b exp 0001", gnt); else passed++;
    total++; if (got0 !== expVec(0)) $display("FAIL reset_model got %h exp %h", got0, expVec(0)); else passed++;
  endtask

  task automatic test_single();
    logic [N+W+1:0] e;
    pulse_reset();
    req = 4'b0001; rv = 16'h0003;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 1) req = '0;
      case (i)
        1:       e = {4'b0001, 1'b0, 4'h9, 1'b1};
        2:       e = {4'b0000, 1'b1, 4'h3, 1'b1};
        3:       e = {4'b0000, 1'b0, 4'h3, 1'b1};
        default: e = {4'b0000, 1'b0, 4'h3, 1'b0};
      endcase
      total++; if (got0 !== e) $display("FAIL single_c%0d got %h exp %h", i, got0, e); else passed++;
      total++; if (got0 !== expVec(0)) $display("FAIL single_model_c%0d got %h exp %h", i, got0, expVec(0)); else passed++;
    end
  endtask

  task automatic test_round_robin();
    int tq[$], gq[$], vq[$];
    int rrT[5] = '{1, 5, 9, 13, 17};
    int rrG[5] = '{0, 1, 2, 3, 0};
    int rrV[5] = '{1, 2, 3, 4, 1};
    pulse_reset();
    req = 4'b1111; rv = 16'h4321;
    for (int i = 1; i <= 19; i++) begin
      tick();
      if (gnt != '0) begin tq.push_back(i); gq.push_back(onehotIdx(gnt)); end
      if (oVld) vq.push_back(int'(oVal));
      total++; if (got0 !== expVec(0)) $display("FAIL rr_model_c%0d got %h exp %h", i, got0, expVec(0)); else passed++;
    end
    total++;
    if (tq.size() != 5 || vq.size() != 5) $display("FAIL rr_count grants %0d vals %0d exp 5", tq.size(), vq.size());
    else begin
      passed++;
      for (int k = 0; k < 5; k++) begin
        total++;
        if (tq[k] != rrT[k] || gq[k] != rrG[k] || vq[k] != rrV[k])
          $display("FAIL rr_seq%0d got t%0d g%0d v%0d exp t%0d g%0d v%0d", k, tq[k], gq[k], vq[k], rrT[k], rrG[k], rrV[k]);
        else passed++;
      end
    end
  endtask

  task automatic test_wrap_skip();
    int gq[$];
    pulse_reset();
    req = 4'b0100; rv = 16'($urandom);
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (gnt != '0) gq.push_back(onehotIdx(gnt));
      if (i == 1) req = '0;
      if (i == 3) req = 4'b0101;
      total++; if (got0 !== expVec(0)) $display("FAIL wrap_model_c%0d got %h exp %h", i, got0, expVec(0)); else passed++;
    end
    total++;
    if (gq.size() < 3 || gq[0] != 2 || gq[1] != 0 || gq[2] != 2)
      $display("FAIL wrap_order got n%0d first %0d,%0d,%0d exp 2,0,2", gq.size(),
               (gq.size() > 0) ? gq[0] : -1, (gq.size() > 1) ? gq[1] : -1, (gq.size() > 2) ? gq[2] : -1);
    else passed++;
  endtask

  task automatic test_mid_reset();
    pulse_reset();
    req = 4'b0100; rv = 16'h0A00;
    tick();
    total++; if (gnt !== 4'b0100) $display("FAIL midrst_gnt got %b exp 0100", gnt); else passed++;
    #2 arst = 1'b1; req = '0;
    #1;
    total++; if (got0 !== RSTV) $display("FAIL midrst_async got %h exp %h", got0, RSTV); else passed++;
    model_reset();
    tick();
    arst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (got0 !== RSTV) $display("FAIL midrst_idle_c%0d got %h exp %h", i, got0, RSTV); else passed++;
    end
    req = 4'b0010; rv = 16'h0050;
    tick();
    req = '0;
    total++; if (gnt !== 4'b0010) $display("FAIL midrst_regnt got %b exp 0010", gnt); else passed++;
    tick();
    total++; if (oVal !== 4'h5 || oVld !== 1'b1) $display("FAIL midrst_val got %h/%b exp 5/1", oVal, oVld); else passed++;
    total++; if (got0 !== expVec(0)) $display("FAIL midrst_model got %h exp %h", got0, expVec(0)); else passed++;
  endtask

  task automatic test_random();
    pulse_reset();
    for (int i = 0; i < 400; i++) begin
      req  = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      req0 = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      rv   = 16'($urandom);
      rv0  = 16'($urandom);
      if ($urandom_range(0, 99) < 3) pulse_reset();
      else tick();
      total++; if (got0 !== expVec(0)) $display("FAIL rand_h2_c%0d got %h exp %h", cyc, got0, expVec(0)); else passed++;
      total++; if (got1 !== expVec(1)) $display("FAIL rand_h0_c%0d got %h exp %h", cyc, got1, expVec(1)); else passed++;
`ifdef VALUE_REG_ARB_UPD_CNT_EN
      total++; if (int'(cnt) != expCnt(0)) $display("FAIL rand_cnt_c%0d got %0d exp %0d", cyc, cnt, expCnt(0)); else passed++;
`endif
    end
  endtask

  task automatic test_hold0();
    int lastT, lastG, g;
    lastT = -1; lastG = -1;
    pulse_reset();
    req0 = 4'b0011; rv0 = 16'($urandom);
    for (int i = 1; i <= 600; i++) begin
      tick();
      total++; if (got1 !== expVec(1)) $display("FAIL h0_model_c%0d got %h exp %h", i, got1, expVec(1)); else passed++;
      if (gnt0 != '0) begin
        g = onehotIdx(gnt0);
        total++;
        if (lastT >= 0 && (i - lastT != 2 || g == lastG))
          $display("FAIL h0_alt_c%0d got gap %0d req %0d exp gap 2 other than %0d", i, i - lastT, g, lastG);
        else passed++;
        lastT = i; lastG = g;
      end
`ifdef VALUE_REG_ARB_UPD_CNT_EN
      total++; if (int'(cnt0) != expCnt(1)) $display("FAIL h0_cnt_c%0d got %0d exp %0d", i, cnt0, expCnt(1)); else passed++;
`endif
    end
`ifdef VALUE_REG_ARB_UPD_CNT_EN
    total++; if (cnt0 !== 8'd255) $display("FAIL h0_cnt_sat got %0d exp 255", cnt0); else passed++;
`endif
    req0 = '0;
  endtask

  initial begin
    hold[0] = 2;
    hold[1] = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap_skip();
    test_mid_reset();
    test_random();
    test_hold0();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
